// File: rtl/uart_receiver_if.sv
// Receive-side bundle of the 8N1 UART link: serial input plus the byte / error
// strobes handed to comm-side logic, and the receiver FSM state for observation.
interface uart_receiver_if;
  // tx_new_byte acts as a valid with no ready: tx_byte is valid for exactly the
  // strobe cycle, and the consumer must take it then because there is no backpressure.
  logic       uart_rx;
  logic       tx_new_byte;
  logic [7:0] tx_byte;
  logic       frame_error;
  logic       rx_busy;
  logic [2:0] rx_state;

  modport master (
    input  uart_rx,
    output tx_new_byte,
    output tx_byte,
    output frame_error,
    output rx_busy,
    output rx_state
  );

  modport slave (
    output uart_rx,
    input  tx_new_byte,
    input  tx_byte,
    input  frame_error,
    input  rx_busy,
    input  rx_state
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes uart_rx, deframes start/8 data LSB-first/stop.
// Optional macro UART_RX_MAJORITY_EN: 3-sample majority vote around each sample point.
module uart_receiver #(
  parameter int comm_clk_frequency = 100000000,
  parameter int baud_rate          = 115200
) (
  input  logic            clk,
  input  logic            reset,
  uart_receiver_if.master bus
);

  localparam logic [15:0] baud_delay = 16'((comm_clk_frequency / baud_rate) - 1);
  localparam logic [15:0] half_delay = 16'(((comm_clk_frequency / baud_rate) / 2) - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic [15:0] r_delay_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_tx_byte;
  logic        r_tx_new_byte;
  logic        r_frame_error;
  logic        r_rx_busy;

  logic [15:0] w_target;
  logic        w_sample_pt;
  logic        w_sample;

  // The start bit is sampled half a bit in; every later bit a full bit after that.
  assign w_target = (r_state == ST_START) ? half_delay : baud_delay;

`ifdef UART_RX_MAJORITY_EN
  logic r_smp_early;
  logic r_smp_mid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_smp_early <= 1'b1;
      r_smp_mid   <= 1'b1;
    end else begin
      if (r_delay_cnt == w_target - 16'd1) r_smp_early <= r_rx_s2;
      if (r_delay_cnt == w_target)         r_smp_mid   <= r_rx_s2;
    end
  end

  // Decide one cycle after the nominal point, once the third vote is visible.
  assign w_sample_pt = (r_delay_cnt == w_target + 16'd1);
  assign w_sample    = (r_smp_early & r_smp_mid) | (r_smp_early & r_rx_s2) |
                       (r_smp_mid & r_rx_s2);
`else
  assign w_sample_pt = (r_delay_cnt == w_target);
  assign w_sample    = r_rx_s2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_s1       <= 1'b1;
      r_rx_s2       <= 1'b1;
      r_state       <= ST_IDLE;
      r_delay_cnt   <= 16'd0;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'h00;
      r_tx_byte     <= 8'h00;
      r_tx_new_byte <= 1'b0;
      r_frame_error <= 1'b0;
      r_rx_busy     <= 1'b0;
    end else begin
      r_rx_s1       <= bus.uart_rx;
      r_rx_s2       <= r_rx_s1;
      r_tx_new_byte <= 1'b0;
      r_frame_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_delay_cnt <= 16'd0;
          if (!r_rx_s2) begin
            r_state   <= ST_START;
            r_rx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (w_sample_pt) begin
            r_delay_cnt <= 16'd0;
            if (!w_sample) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= 3'd0;
            end else begin
              r_state   <= ST_IDLE;
              r_rx_busy <= 1'b0;
            end
          end else begin
            r_delay_cnt <= r_delay_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (w_sample_pt) begin
            r_delay_cnt <= 16'd0;
            r_shift     <= {w_sample, r_shift[7:1]};
            r_bit_cnt   <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= ST_STOP;
          end else begin
            r_delay_cnt <= r_delay_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (w_sample_pt) begin
            r_delay_cnt <= 16'd0;
            if (w_sample) begin
              r_tx_byte     <= r_shift;
              r_tx_new_byte <= 1'b1;
              r_state       <= ST_IDLE;
              r_rx_busy     <= 1'b0;
            end else begin
              r_frame_error <= 1'b1;
              r_state       <= ST_BREAK;
            end
          end else begin
            r_delay_cnt <= r_delay_cnt + 16'd1;
          end
        end
        ST_BREAK: begin
          // A held-low line reports one error and then waits here silently.
          if (r_rx_s2) begin
            r_state     <= ST_IDLE;
            r_rx_busy   <= 1'b0;
            r_delay_cnt <= 16'd0;
          end else begin
            r_delay_cnt <= r_delay_cnt + 16'd1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rx_busy   <= 1'b0;
          r_delay_cnt <= 16'd0;
        end
      endcase
    end
  end

  assign bus.tx_new_byte = r_tx_new_byte;
  assign bus.tx_byte     = r_tx_byte;
  assign bus.frame_error = r_frame_error;
  assign bus.rx_busy     = r_rx_busy;
  assign bus.rx_state    = r_state;

endmodule
